// File: rtl/imac_pkg.sv
// Shared types and default constants for the IMAC host driver.
package imac_pkg;

  localparam int unsigned WBUF_DEPTH_DFLT = 16;
  localparam int unsigned DRAIN_CYC_DFLT  = 2;
  localparam int unsigned LOAD_CYC        = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StLoad,
    StStream,
    StDrain,
    StReadHi,
    StReadLo,
    StResp
  } state_e;

endpackage

// File: rtl/imac_wbuf.sv
// Weight byte buffer: sequential writes from index 0, indexed combinational read.
module imac_wbuf
  import imac_pkg::*;
#(
  parameter int unsigned  WBUF_DEPTH = WBUF_DEPTH_DFLT,
  localparam int unsigned AW         = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] ridx,
  output logic [7:0]    rdata,
  output logic [AW:0]   count
);

  logic [7:0]  mem_q [WBUF_DEPTH];
  logic [AW:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (we) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Storage needs no reset; only the write pointer defines valid contents.
  always_ff @(posedge clk) begin
    if (we && !clr) begin
      mem_q[count_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];
  assign count = count_q;

endmodule

// File: rtl/imac_host_driver.sv
// Host-side sequencer for the IMAC: buffers weights, loads, streams, and reads back the result.
// Optional IMAC_DRV_OE_CHECK_EN flags unexpected MAC output-enable patterns on rsp_err.
module imac_host_driver
  import imac_pkg::*;
#(
  parameter int unsigned  WBUF_DEPTH = WBUF_DEPTH_DFLT,
  parameter int unsigned  DRAIN_CYC  = DRAIN_CYC_DFLT,
  localparam int unsigned AW         = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [6:0]  cmd_act,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] cmd_bias,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [7:0]  w_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic        busy,
  output logic        mac_rst_n,
  output logic [7:0]  mac_ui_in,
  output logic [7:0]  mac_uio_in,
  input  logic [7:0]  mac_uo_out,
  input  logic [7:0]  mac_uio_out,
  input  logic [7:0]  mac_uio_oe
);

  localparam int unsigned CntW = 8;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [6:0]  act_q, act_d;
  logic [AW:0] len_q, len_d;
  logic [31:0] bias_q, bias_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic        mac_rst_n_q, mac_rst_n_d;

  logic        wb_clr, wb_we;
  logic [7:0]  wb_rdata;
  logic [AW:0] wb_count;
  logic [4:0]  len_eff;
  logic        oe_bad;

`ifdef IMAC_DRV_OE_CHECK_EN
  assign oe_bad = mode_q ? (mac_uio_oe != 8'h00) : (mac_uio_oe != 8'hFF);
`else
  logic unused_oe;
  assign unused_oe = ^mac_uio_oe;
  assign oe_bad    = 1'b0;
`endif

  imac_wbuf #(
    .WBUF_DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk  (clk),
    .rst  (rst),
    .clr  (wb_clr),
    .we   (wb_we),
    .wdata(w_data),
    .ridx (cnt_q[AW-1:0]),
    .rdata(wb_rdata),
    .count(wb_count)
  );

  // Zero length means one weight; never exceed the buffer.
  always_comb begin
    len_eff = (cmd_len == 4'd0) ? 5'd1 : {1'b0, cmd_len};
    if (len_eff > 5'(WBUF_DEPTH)) len_eff = 5'(WBUF_DEPTH);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    act_d       = act_q;
    len_d       = len_q;
    bias_d      = bias_q;
    res_d       = res_q;
    err_d       = err_q;
    cmd_ready   = 1'b0;
    w_ready     = 1'b0;
    rsp_valid   = 1'b0;
    wb_clr      = 1'b0;
    wb_we       = 1'b0;
    mac_ui_in   = 8'h00;
    mac_uio_in  = 8'h00;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          act_d   = cmd_act;
          len_d   = len_eff[AW:0];
          bias_d  = cmd_bias;
          err_d   = 1'b0;
          wb_clr  = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        w_ready = (wb_count < len_q);
        wb_we   = w_valid && w_ready;
        if (wb_count == len_q) begin
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        mac_ui_in = {mode_q, act_q};
        if (cnt_q == CntW'(LOAD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StStream;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStream: begin
        mac_ui_in  = wb_rdata;
        mac_uio_in = bias_q[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == CntW'(len_q - 1'b1)) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYC == 0) ? StReadHi : StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DRAIN_CYC - 1)) begin
          state_d = StReadHi;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReadHi: begin
        res_d[31:16] = {mac_uo_out, mac_uio_out};
        if (oe_bad) err_d = 1'b1;
        state_d = StReadLo;
      end
      StReadLo: begin
        res_d[15:0] = {mac_uo_out, mac_uio_out};
        if (oe_bad) err_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // MAC is held in reset only while loading mode/activation.
    mac_rst_n_d = (state_d != StLoad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      act_q       <= '0;
      len_q       <= '0;
      bias_q      <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      mac_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      act_q       <= act_d;
      len_q       <= len_d;
      bias_q      <= bias_d;
      res_q       <= res_d;
      err_q       <= err_d;
      mac_rst_n_q <= mac_rst_n_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign mac_rst_n  = mac_rst_n_q;

endmodule

// File: tb/tb_imac_host_driver.sv
// Scoreboard bench for imac_host_driver with a behavioural MAC driving the result pins.
module tb_imac_host_driver;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_mode;
  logic [6:0]  cmd_act;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_bias;
  logic        w_valid, w_ready;
  logic [7:0]  w_data;
  logic        rsp_valid, rsp_ready, rsp_err, busy, mac_rst_n;
  logic [31:0] rsp_result;
  logic [7:0]  mac_ui_in, mac_uio_in;
  logic [7:0]  mac_uo_out = 8'h00;
  logic [7:0]  mac_uio_out = 8'h00;
  logic [7:0]  mac_uio_oe;

  imac_host_driver dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_act    (cmd_act),
    .cmd_len    (cmd_len),
    .cmd_bias   (cmd_bias),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mac_rst_n  (mac_rst_n),
    .mac_ui_in  (mac_ui_in),
    .mac_uio_in (mac_uio_in),
    .mac_uo_out (mac_uo_out),
    .mac_uio_out(mac_uio_out),
    .mac_uio_oe (mac_uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural MAC: observes the pins, presents result halves when the driver reads them.
  bit          run = 1'b0;
  int          ph = 0;
  int          cur_len = 1;
  int          drain_bad = 0;
  logic        m_mode;
  logic [6:0]  m_act;
  logic [31:0] m_acc, m_bias, m_res;
  logic [7:0]  ld_ui[$];
  logic [7:0]  tr_ui[$];
  logic [7:0]  tr_uio[$];

  always @(negedge clk) begin
    if (!busy) begin
      run = 1'b0;
    end else if (!mac_rst_n) begin
      run    = 1'b1;
      ph     = 0;
      m_mode = mac_ui_in[7];
      m_act  = mac_ui_in[6:0];
      m_acc  = '0;
      m_bias = '0;
      ld_ui.push_back(mac_ui_in);
    end else if (run) begin
      if (ph < cur_len) begin
        m_acc = m_acc + 32'(m_act) * 32'(mac_ui_in);
        m_bias[8*(ph%4) +: 8] = mac_uio_in;
        tr_ui.push_back(mac_ui_in);
        tr_uio.push_back(mac_uio_in);
      end else if (ph < cur_len + D) begin
        if (mac_ui_in != 8'h00 || mac_uio_in != 8'h00) drain_bad++;
      end
      m_res = m_mode ? (m_bias - m_acc) : (m_bias + m_acc);
      if (ph == cur_len + D)          {mac_uo_out, mac_uio_out} = m_res[31:16];
      else if (ph == cur_len + D + 1) {mac_uo_out, mac_uio_out} = m_res[15:0];
      else                            {mac_uo_out, mac_uio_out} = 16'hDEAD;
      ph++;
    end
  end

  logic [7:0]  wts [16];
  logic [31:0] exp_res[$];
  logic        exp_err[$];
  int          acc_cyc, last_cyc;

  function automatic logic [31:0] mac_ref(input logic mode, input logic [6:0] act, input int n,
                                          input logic [31:0] bias);
    logic [31:0] acc = '0;
    logic [31:0] bs = '0;
    for (int k = 0; k < n; k++) begin
      acc = acc + 32'(act) * 32'(wts[k]);
      bs[8*(k%4) +: 8] = bias[8*(k%4) +: 8];
    end
    return mode ? (bs - acc) : (bs + acc);
  endfunction

  function automatic logic [63:0] pack_q(input bit uio);
    logic [63:0] p = '0;
    int n = uio ? tr_uio.size() : tr_ui.size();
    for (int k = 0; k < n && k < 8; k++) p = {p[55:0], (uio ? tr_uio[k] : tr_ui[k])};
    return p;
  endfunction

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_ctl"}, 64'({cmd_ready, w_ready, rsp_valid, rsp_err, busy, mac_rst_n}),
              64'(6'b100000));
    check_val({tag, "_result"}, 64'(rsp_result), 64'd0);
    check_val({tag, "_mac_in"}, 64'({mac_ui_in, mac_uio_in}), 64'd0);
  endtask

  task automatic send_cmd(input logic mode, input logic [6:0] act, input logic [3:0] len,
                          input logic [31:0] bias);
    bit got = 1'b0;
    cmd_mode = mode; cmd_act = act; cmd_len = len; cmd_bias = bias; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check_val("cmd_accept", 64'(got), 64'd1);
  endtask

  task automatic send_wts(input int n, input bit gap);
    int idx = 0;
    int slot = 0;
    while (idx < n && slot < 200) begin
      w_valid = !(gap && (slot % 3 == 2));
      w_data  = wts[idx];
      @(negedge clk);
      check_val("fill_pins", 64'({mac_rst_n, mac_ui_in, mac_uio_in}), 64'({1'b1, 16'h0}));
      if (w_valid && w_ready) begin idx++; last_cyc = cyc; end
      @(posedge clk); #1;
      slot++;
    end
    w_valid = 1'b0;
    check_val("fill_done", 64'(idx), 64'(n));
  endtask

  task automatic get_rsp(input int hold);
    int t = 0;
    int f = last_cyc - acc_cyc + 1;
    if (hold == 0) rsp_ready = 1'b1;
    @(negedge clk);
    while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
    check_val("rsp_valid", 64'(rsp_valid), 64'd1);
    if (!rsp_valid) begin
      void'(exp_res.pop_front()); void'(exp_err.pop_front());
      rsp_ready = 1'b0;
      return;
    end
    check_val("latency", 64'(cyc - acc_cyc), 64'(f + 2 + cur_len + D + 2 + 1));
    check_val("drain_zero", 64'(drain_bad), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (h == 2) begin cmd_valid = 1'b1; cmd_len = 4'd1; cmd_act = 7'h11; end
      if (h == 6) cmd_valid = 1'b0;
      @(negedge clk);
      check_val("hold_valid", 64'(rsp_valid), 64'd1);
      check_val("hold_result", 64'(rsp_result), 64'(exp_res[0]));
      if (h >= 2 && h < 6) check_val("busy_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    if (hold != 0) begin @(posedge clk); #1; rsp_ready = 1'b1; @(negedge clk); end
    check_val("rsp_result", 64'(rsp_result), 64'(exp_res.pop_front()));
    check_val("rsp_err", 64'(rsp_err), 64'(exp_err.pop_front()));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_val("back_idle", 64'({busy, cmd_ready}), 64'(2'b01));
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic mode, input logic [6:0] act, input logic [3:0] len,
                         input logic [31:0] bias, input logic [7:0] oe, input bit gap,
                         input int hold);
    int   n = (len == 4'd0) ? 1 : int'(len);
    logic e;
    mac_uio_oe = oe;
    cur_len    = n;
    drain_bad  = 0;
    ld_ui.delete(); tr_ui.delete(); tr_uio.delete();
`ifdef IMAC_DRV_OE_CHECK_EN
    e = mode ? (oe != 8'h00) : (oe != 8'hFF);
`else
    e = 1'b0;
`endif
    exp_res.push_back(mac_ref(mode, act, n, bias));
    exp_err.push_back(e);
    send_cmd(mode, act, len, bias);
    send_wts(n, gap);
    get_rsp(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b;
    logic [63:0] e_ui, e_uio;
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_act = '0; cmd_len = '0; cmd_bias = '0;
    w_valid = 1'b0; w_data = '0; rsp_ready = 1'b0; mac_uio_oe = 8'hFF;
    #2;
    check_reset_outs("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("idle_mac_rst_n", 64'(mac_rst_n), 64'd1);
    @(posedge clk); #1;

    // Inference reference case.
    wts[0] = 8'd2; wts[1] = 8'd3; wts[2] = 8'd4;
    run_txn(1'b0, 7'd5, 4'd3, 32'h01020304, 8'hFF, 1'b0, 0);
    check_val("load_cycles", 64'(ld_ui.size()), 64'd2);
    check_val("load_ui", 64'({ld_ui[0], ld_ui[1]}), 64'(16'h0505));
    check_val("stream_ui", pack_q(1'b0), 64'(24'h020304));
    check_val("stream_uio", pack_q(1'b1), 64'(24'h040302));

    // Zero length behaves as one weight.
    wts[0] = 8'h7F;
    run_txn(1'b1, 7'd3, 4'd0, 32'hA5A51234, 8'h00, 1'b0, 0);
    check_val("len0_cycles", 64'(tr_ui.size()), 64'd1);
    check_val("len0_stream", 64'({tr_ui[0], tr_uio[0]}), 64'(16'h7F34));

    // Gappy weight delivery must not alter streaming.
    b = $urandom;
    e_ui = '0; e_uio = '0;
    for (int k = 0; k < 6; k++) begin
      wts[k] = 8'($urandom_range(0, 255));
      e_ui   = {e_ui[55:0], wts[k]};
      e_uio  = {e_uio[55:0], b[8*(k%4) +: 8]};
    end
    run_txn(1'b0, 7'h7F, 4'd6, b, 8'hFF, 1'b1, 0);
    check_val("gap_stream_ui", pack_q(1'b0), e_ui);
    check_val("gap_stream_uio", pack_q(1'b1), e_uio);

    // Backpressured response with an ignored command in flight.
    for (int k = 0; k < 4; k++) wts[k] = 8'($urandom_range(0, 255));
    run_txn(1'b1, 7'h2A, 4'd4, $urandom, 8'h00, 1'b0, 10);

    // Reset in the middle of streaming.
    for (int k = 0; k < 5; k++) wts[k] = 8'(k + 10);
    cur_len = 5; ld_ui.delete(); tr_ui.delete(); tr_uio.delete();
    mac_uio_oe = 8'hFF;
    send_cmd(1'b0, 7'h09, 4'd5, 32'hCAFEF00D);
    send_wts(5, 1'b0);
    t = 0;
    while (tr_ui.size() < 3 && t < 100) begin @(negedge clk); #1; t++; end
    check_val("abort_reached_stream2", 64'(tr_ui.size()), 64'd3);
    rst = 1'b1;
    #1;
    check_reset_outs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-length transaction after the abort.
    for (int k = 0; k < 15; k++) wts[k] = 8'($urandom_range(0, 255));
    run_txn(1'b0, 7'($urandom_range(0, 127)), 4'd15, $urandom, 8'hFF, 1'b0, 0);
    check_val("full_stream_cycles", 64'(tr_ui.size()), 64'd15);

    // Wrong output-enable pattern for inference.
    wts[0] = 8'h21; wts[1] = 8'h43;
    run_txn(1'b0, 7'h01, 4'd2, 32'h11223344, 8'h00, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/imac_host_driver.md
IMAC_HOST_DRIVER -- requirements
Module: imac_host_driver

Interface
REQ-001 Parameter WBUF_DEPTH, default 16, weight-buffer entries; SHALL be a power of two, range 2..16.
REQ-002 Parameter DRAIN_CYC, default 2, idle cycles between the last streamed weight and result readback.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_mode  in  1  0 = inference, 1 = training.
- cmd_act  in  7  input activation.
- cmd_len  in  4  weight count; 0 is treated as 1.
- cmd_bias  in  32  bias word.
- w_valid/w_ready  in/out  1/1  weight-byte handshake.
- w_data  in  8  weight byte.
- rsp_valid/rsp_ready  out/in  1/1  result handshake.
- rsp_result  out  32  reassembled MAC result.
- rsp_err  out  1  interface-direction error flag.
- busy  out  1  high in every state except IDLE.
- mac_rst_n  out  1  MAC reset, active-low.
- mac_ui_in  out  8  MAC dedicated inputs.
- mac_uio_in  out  8  MAC bidirectional input path.
- mac_uo_out  in  8  MAC result[31:24].
- mac_uio_out  in  8  MAC result[23:16].
- mac_uio_oe  in  8  MAC bidirectional output enables.

Function
REQ-004 FSM states SHALL be IDLE, FILL, LOAD, STREAM, DRAIN, READ_HI, READ_LO, RESP.
REQ-005 IDLE: cmd_ready=1; on cmd_valid, latch mode/act/len/bias, clear the buffer, go to FILL; cmd_ready=0 in all other states.
REQ-006 FILL: w_ready=1 while the count is below the latched length; each w_valid&w_ready writes one byte; go to LOAD the cycle after the count reaches the length; w_ready=0 outside FILL.
REQ-007 LOAD: exactly 2 cycles with mac_rst_n=0 and mac_ui_in={mode,act}; mac_rst_n SHALL be 1 in every other state except IDLE.
REQ-008 STREAM: exactly len cycles; cycle k drives mac_ui_in=buffer[k] and mac_uio_in=bias byte (k mod 4), byte 0 = bias[7:0]; no stall is permitted.
REQ-009 DRAIN: DRAIN_CYC cycles; mac_ui_in=0, mac_uio_in=0.
REQ-010 READ_HI captures {mac_uo_out,mac_uio_out} into rsp_result[31:16]; READ_LO captures it into rsp_result[15:0]; one cycle each.
REQ-011 RESP: rsp_valid=1 with rsp_result/rsp_err held stable until rsp_ready; the accept cycle returns to IDLE; rsp_valid=1 with rsp_ready=1 on entry completes in that cycle.
REQ-012 mac_ui_in and mac_uio_in SHALL be 0 in IDLE, FILL and RESP.
REQ-013 A cmd_valid arriving while busy SHALL be ignored, not queued.
REQ-014 Total latency from command accept to rsp_valid SHALL be (fill cycles)+2+len+DRAIN_CYC+2+1 cycles.

Reset
REQ-015 On rst assertion, at any time including mid-transaction, outputs SHALL take these values: state=IDLE, cmd_ready=1, w_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0, mac_rst_n=0, mac_ui_in=0, mac_uio_in=0, buffer pointers=0.
REQ-016 The first IDLE cycle after rst deassertion SHALL set mac_rst_n=1.

Configuration
REQ-017 With IMAC_DRV_OE_CHECK_EN defined, READ_HI/READ_LO SHALL set rsp_err=1 if mac_uio_oe!=8'hFF in inference mode, or !=8'h00 in training mode; the flag clears on command accept.
REQ-018 Without IMAC_DRV_OE_CHECK_EN, rsp_err SHALL be tied 0, mac_uio_oe SHALL be unused, and the port list SHALL be unchanged.

Structure
REQ-019 Package imac_pkg SHALL hold the state enum, the default WBUF_DEPTH/DRAIN_CYC constants and LOAD_CYC=2.
REQ-020 The weight buffer SHALL be sub-module imac_wbuf: synchronous write, index read, count output, clear input.

Verification
REQ-021 Inference case: act=5, len=3, weights 2,3,4, bias=0x01020304 -> LOAD shows mac_ui_in=0x05; STREAM shows ui 2,3,4 and uio 04,03,02; rsp_result equals the MAC model output.
REQ-022 cmd_len=0 with one weight 0x7F -> exactly one STREAM cycle; response delivered.
REQ-023 w_valid gaps during FILL (1 of 3 cycles) -> mac_rst_n stays 1 until the buffer is full; the STREAM sequence is unchanged.
REQ-024 rsp_ready held low for 10 cycles -> rsp_valid and rsp_result stable; a second cmd_valid is ignored.
REQ-025 rst pulsed during STREAM cycle 2 -> all outputs take their reset values immediately; a next command completes normally.
REQ-026 With IMAC_DRV_OE_CHECK_EN: mode=0, mac_uio_oe=0x00 -> rsp_err=1. Without the macro: rsp_err=0.
